// File: rtl/h_rx_stream_12_7.sv
// Hamming(12,7) SECDED receive stream: decodes each accepted codeword,
// queues {ErrorD, ErrorC, data} in a small FIFO and keeps saturating
// counts of corrected and uncorrectable words.
module h_rx_stream_12_7 #(
  parameter int DEPTH       = 4,
  parameter bit DROP_UNCORR = 1'b0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [11:0] i_CodeWord,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [6:0]  o_DecodWord,
  output logic        o_ErrorC,
  output logic        o_ErrorD,
  input  logic        i_ClrCnt,
  output logic [7:0]  o_CntC,
  output logic [7:0]  o_CntD,
  output logic [3:0]  o_Level
);

  localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_L = 4'(DEPTH);

  // Decode path
  logic [4:0]  syndrome;
  logic [3:0]  errPos;
  logic [11:0] flipMask;
  logic [11:0] corrected;
  logic        decErrC;
  logic        decErrD;
  logic [8:0]  decWord;

  // Handshake
  logic accept;
  logic push;
  logic pop;

  // State
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [3:0]       level_q, level_d;
  logic [7:0]       cntC_q, cntC_d;
  logic [7:0]       cntD_q, cntD_d;
  logic             readyEn_q;
  logic [8:0]       mem [DEPTH];
  logic [8:0]       headWord;

  // Recompute parity, form the syndrome and correct a single-bit error
  always_comb begin
    syndrome[0] = i_CodeWord[0] ^ (^i_CodeWord[11:1]);
    syndrome[1] = i_CodeWord[1] ^ i_CodeWord[3] ^ i_CodeWord[5] ^ i_CodeWord[7]
                  ^ i_CodeWord[9] ^ i_CodeWord[11];
    syndrome[2] = i_CodeWord[2] ^ i_CodeWord[3] ^ i_CodeWord[6] ^ i_CodeWord[7]
                  ^ i_CodeWord[10] ^ i_CodeWord[11];
    syndrome[3] = i_CodeWord[4] ^ i_CodeWord[5] ^ i_CodeWord[6] ^ i_CodeWord[7];
    syndrome[4] = i_CodeWord[8] ^ i_CodeWord[9] ^ i_CodeWord[10] ^ i_CodeWord[11];
    errPos      = syndrome[4:1];
    flipMask    = '0;
    decErrC     = 1'b0;
    decErrD     = 1'b0;
    if (syndrome != 5'd0) begin
      if (syndrome[0] && (errPos < 4'd12)) begin
        flipMask = 12'd1 << errPos;
        decErrC  = 1'b1;
      end else begin
        decErrD = 1'b1;
      end
    end
    corrected = i_CodeWord ^ flipMask;
    decWord   = {decErrD, decErrC, corrected[11:9], corrected[7:5], corrected[3]};
  end

  assign accept = i_Valid && o_Ready;
  assign push   = accept && !(DROP_UNCORR && decErrD);
  assign pop    = o_Valid && i_Ready;

  // Next-state for pointers, occupancy and the saturating error counters
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    cntC_d  = cntC_q;
    cntD_d  = cntD_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase
    if (i_ClrCnt) begin
      cntC_d = '0;
      cntD_d = '0;
    end else begin
      if (accept && decErrC && (cntC_q != 8'hFF)) begin
        cntC_d = cntC_q + 8'd1;
      end
      if (accept && decErrD && (cntD_q != 8'hFF)) begin
        cntD_d = cntD_q + 8'd1;
      end
    end
  end

  // Control state; readyEn_q holds o_Ready low until the first edge after reset
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      level_q   <= '0;
      cntC_q    <= '0;
      cntD_q    <= '0;
      readyEn_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      level_q   <= level_d;
      cntC_q    <= cntC_d;
      cntD_q    <= cntD_d;
      readyEn_q <= 1'b1;
    end
  end

  // Storage needs no reset: an empty FIFO masks whatever the entries hold
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wrPtr_q] <= decWord;
    end
  end

  assign headWord    = o_Valid ? mem[rdPtr_q] : 9'd0;
  assign o_Valid     = (level_q != 4'd0);
  assign o_Ready     = readyEn_q && (level_q < DEPTH_L);
  assign o_DecodWord = headWord[6:0];
  assign o_ErrorC    = headWord[7];
  assign o_ErrorD    = headWord[8];
  assign o_CntC      = cntC_q;
  assign o_CntD      = cntD_q;
  assign o_Level     = level_q;

endmodule

// File: tb/tb_h_rx_stream_12_7.sv
// Self-checking bench for h_rx_stream_12_7: scoreboard of expected head
// words built from an independent search-based SECDED decoder.
module tb_h_rx_stream_12_7;

  logic        clk;
  logic        rst;
  logic        validIn;
  logic        readyOut;
  logic [11:0] codeWord;
  logic        validOut;
  logic        readyIn;
  logic [6:0]  decodOut;
  logic        errCOut;
  logic        errDOut;
  logic        clrCnt;
  logic [7:0]  cntCOut;
  logic [7:0]  cntDOut;
  logic [3:0]  levelOut;

  logic        valid2In;
  logic        ready2In;
  logic        clr2;
  logic        ready2Out;
  logic        valid2Out;
  logic [6:0]  decod2Out;
  logic        errC2Out;
  logic        errD2Out;
  logic [7:0]  cntC2Out;
  logic [7:0]  cntD2Out;
  logic [3:0]  level2Out;

  int compareCount;
  int mismatchCount;

  logic [8:0]  sb [$];
  logic [8:0]  monExp;
  logic [11:0] codeTable [128];
  int          expCntC;
  int          expCntD;

  h_rx_stream_12_7 #(.DEPTH(4), .DROP_UNCORR(1'b0)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(validIn), .o_Ready(readyOut),
    .i_CodeWord(codeWord), .o_Valid(validOut), .i_Ready(readyIn),
    .o_DecodWord(decodOut), .o_ErrorC(errCOut), .o_ErrorD(errDOut),
    .i_ClrCnt(clrCnt), .o_CntC(cntCOut), .o_CntD(cntDOut), .o_Level(levelOut)
  );

  h_rx_stream_12_7 #(.DEPTH(4), .DROP_UNCORR(1'b1)) dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(valid2In), .o_Ready(ready2Out),
    .i_CodeWord(codeWord), .o_Valid(valid2Out), .i_Ready(ready2In),
    .o_DecodWord(decod2Out), .o_ErrorC(errC2Out), .o_ErrorD(errD2Out),
    .i_ClrCnt(clr2), .o_CntC(cntC2Out), .o_CntD(cntD2Out), .o_Level(level2Out)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [11:0] encode(input logic [6:0] d);
    logic [11:0] c;
    c     = '0;
    c[3]  = d[0];
    c[5]  = d[1];
    c[6]  = d[2];
    c[7]  = d[3];
    c[9]  = d[4];
    c[10] = d[5];
    c[11] = d[6];
    c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4]  = c[5] ^ c[6] ^ c[7];
    c[8]  = c[9] ^ c[10] ^ c[11];
    c[0]  = ^c[11:1];
    return c;
  endfunction

  // Nearest-codeword search: exact hit, distance one, otherwise uncorrectable
  function automatic logic [8:0] expectedOf(input logic [11:0] cw);
    for (int d = 0; d < 128; d++) begin
      if (codeTable[d] == cw) return {2'b00, 7'(d)};
    end
    for (int d = 0; d < 128; d++) begin
      if ($countones(codeTable[d] ^ cw) == 1) return {2'b01, 7'(d)};
    end
    return {2'b10, cw[11:9], cw[7:5], cw[3]};
  endfunction

  function automatic logic [11:0] makeWord(input int kind);
    logic [11:0] c;
    int          b1;
    int          b2;
    c  = encode(7'($urandom_range(0, 127)));
    b1 = $urandom_range(0, 11);
    b2 = (b1 + $urandom_range(1, 11)) % 12;
    if (kind >= 1) c[b1] = ~c[b1];
    if (kind == 2) c[b2] = ~c[b2];
    return c;
  endfunction

  task automatic applyStimulus(input logic [11:0] cw, input logic clr);
    logic [8:0] exp;
    bit         done;
    exp      = expectedOf(cw);
    codeWord = cw;
    validIn  = 1'b1;
    clrCnt   = clr;
    done     = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (readyOut) begin
        done = 1'b1;
        sb.push_back(exp);
        if (clr) begin
          expCntC = 0;
          expCntD = 0;
        end else begin
          if (exp[7] && expCntC < 255) expCntC++;
          if (exp[8] && expCntD < 255) expCntD++;
        end
      end
    end
    if (!done) checkOutput("acceptTimeout", 32'(readyOut), 32'd1);
    @(posedge clk);
    #1;
    validIn = 1'b0;
    clrCnt  = 1'b0;
  endtask

  task automatic drainQueue();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drainLeft", 32'(sb.size()), 32'd0);
    checkOutput("drainLevel", 32'(levelOut), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Valid"}, 32'(validOut), 32'd0);
    checkOutput({tag, "Level"}, 32'(levelOut), 32'd0);
    checkOutput({tag, "Ready"}, 32'(readyOut), 32'd0);
    checkOutput({tag, "Head"}, 32'({errDOut, errCOut, decodOut}), 32'd0);
    checkOutput({tag, "CntC"}, 32'(cntCOut), 32'd0);
    checkOutput({tag, "CntD"}, 32'(cntDOut), 32'd0);
  endtask

  // Scoreboard: compare the head whenever a pop will happen on the next edge
  always @(negedge clk) begin
    if (!rst && validOut && readyIn) begin
      if (sb.size() == 0) begin
        checkOutput("sbUnderflow", 32'(sb.size()), 32'd1);
      end else begin
        monExp = sb.pop_front();
        checkOutput("headWord", 32'({errDOut, errCOut, decodOut}), 32'(monExp));
      end
    end
  end

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    expCntC       = 0;
    expCntD       = 0;
    rst           = 1'b1;
    validIn       = 1'b0;
    readyIn       = 1'b0;
    clrCnt        = 1'b0;
    codeWord      = '0;
    valid2In      = 1'b0;
    ready2In      = 1'b1;
    clr2          = 1'b0;
    for (int d = 0; d < 128; d++) codeTable[d] = encode(7'(d));

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("rst");

    rst = 1'b0;
    #1;
    checkOutput("readyBeforeEdge", 32'(readyOut), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("readyAfterEdge", 32'(readyOut), 32'd1);
    readyIn = 1'b1;

    applyStimulus(12'hFFF, 1'b0);
    checkOutput("fffValid", 32'(validOut), 32'd1);
    checkOutput("fffHead", 32'({errDOut, errCOut, decodOut}), 32'h07F);
    checkOutput("fffCntC", 32'(cntCOut), 32'd0);
    checkOutput("fffCntD", 32'(cntDOut), 32'd0);

    applyStimulus(12'h020, 1'b0);
    checkOutput("corrHead", 32'({errDOut, errCOut, decodOut}), 32'h080);
    checkOutput("corrCntC", 32'(cntCOut), 32'd1);

    applyStimulus(12'h021, 1'b0);
    checkOutput("dblHead", 32'({errDOut, errCOut, decodOut}), 32'h102);
    checkOutput("dblCntD", 32'(cntDOut), 32'd1);

    for (int i = 0; i < 24; i++) applyStimulus(makeWord(i % 3), 1'b0);
    drainQueue();
    checkOutput("mixCntC", 32'(cntCOut), 32'(expCntC));
    checkOutput("mixCntD", 32'(cntDOut), 32'(expCntD));

    // Backpressure: four words fill the FIFO, a fifth waits upstream
    readyIn = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(makeWord(i % 3), 1'b0);
    @(negedge clk);
    checkOutput("fullLevel", 32'(levelOut), 32'd4);
    checkOutput("fullReady", 32'(readyOut), 32'd0);
    @(posedge clk);
    #1;
    fork
      applyStimulus(makeWord(1), 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("holdHead", 32'({errDOut, errCOut, decodOut}), 32'(sb[0]));
          checkOutput("holdReady", 32'(readyOut), 32'd0);
        end
        @(posedge clk);
        #1;
        readyIn = 1'b1;
      end
    join
    drainQueue();

    // Saturation of the corrected counter, then a clear during an accept
    clrCnt = 1'b1;
    @(posedge clk);
    #1;
    clrCnt  = 1'b0;
    expCntC = 0;
    expCntD = 0;
    checkOutput("clrCntC", 32'(cntCOut), 32'd0);
    for (int i = 0; i < 300; i++) applyStimulus(makeWord(1), 1'b0);
    checkOutput("satCntC", 32'(cntCOut), 32'(expCntC));
    checkOutput("satModel", 32'(expCntC), 32'd255);
    applyStimulus(makeWord(1), 1'b1);
    checkOutput("clrAccCntC", 32'(cntCOut), 32'd0);
    checkOutput("clrAccCntD", 32'(cntDOut), 32'd0);
    drainQueue();

    // Reset with three words queued
    readyIn = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(makeWord(0), 1'b0);
    @(negedge clk);
    checkOutput("preRstLevel", 32'(levelOut), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("midRst");
    sb.delete();
    expCntC = 0;
    expCntD = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("relReadyBefore", 32'(readyOut), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("relReadyAfter", 32'(readyOut), 32'd1);
    checkOutput("relLevel", 32'(levelOut), 32'd0);
    readyIn = 1'b1;
    applyStimulus(12'hFFF, 1'b0);
    checkOutput("postRstHead", 32'({errDOut, errCOut, decodOut}), 32'h07F);
    drainQueue();

    // Dropping instance: uncorrectable words counted but not stored
    codeWord = 12'h021;
    valid2In = 1'b1;
    @(negedge clk);
    checkOutput("dropReady", 32'(ready2Out), 32'd1);
    @(posedge clk);
    #1;
    valid2In = 1'b0;
    checkOutput("dropLevel", 32'(level2Out), 32'd0);
    checkOutput("dropValid", 32'(valid2Out), 32'd0);
    checkOutput("dropCntD", 32'(cntD2Out), 32'd1);
    codeWord = 12'h020;
    valid2In = 1'b1;
    @(posedge clk);
    #1;
    valid2In = 1'b0;
    checkOutput("dropKeepValid", 32'(valid2Out), 32'd1);
    checkOutput("dropKeepHead", 32'({errD2Out, errC2Out, decod2Out}), 32'h080);
    checkOutput("dropKeepCntC", 32'(cntC2Out), 32'd1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/h_rx_stream_12_7.md
H_RX_STREAM_12_7 -- requirements
Module: h_rx_stream_12_7

Interface
REQ-001 Parameter DEPTH, default 4; output FIFO depth in entries; legal values 2, 4, 8.
REQ-002 Parameter DROP_UNCORR, default 0; when 1, uncorrectable words are counted but never stored.
REQ-003 i_Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_Rst  input  1  reset, asynchronous assert, active-high.
REQ-005 i_Valid  input  1  upstream codeword valid.
REQ-006 o_Ready  output  1  block can accept a codeword this cycle.
REQ-007 i_CodeWord  input  12  received Hamming(12,7) SECDED codeword.
REQ-008 o_Valid  output  1  FIFO head valid.
REQ-009 i_Ready  input  1  downstream accepts FIFO head.
REQ-010 o_DecodWord  output  7  decoded data at FIFO head.
REQ-011 o_ErrorC  output  1  head word had a corrected single error.
REQ-012 o_ErrorD  output  1  head word had an uncorrectable error; data is uncorrected.
REQ-013 i_ClrCnt  input  1  synchronous clear of both error counters.
REQ-014 o_CntC  output  8  saturating count of corrected words accepted.
REQ-015 o_CntD  output  8  saturating count of uncorrectable words accepted.
REQ-016 o_Level  output  4  current FIFO occupancy, 0..DEPTH.

Function
REQ-017 Codeword layout: bit0 overall parity P0, bits 1,2,4,8 = P1,P2,P4,P8; data bits 3,5,6,7,9,10,11.
REQ-018 Recomputed parity: P0=XOR cw[11:1]; P1=XOR cw{3,5,7,9,11}; P2=XOR cw{3,6,7,10,11}; P4=XOR cw{5,6,7}; P8=XOR cw{9,10,11}.
REQ-019 Syndrome S[4:0] = {cw8,cw4,cw2,cw1,cw0} XOR {P8,P4,P2,P1,P0}.
REQ-020 S==0: no error, flags 0; S[0]==1 and S[4:1]<12: flip cw bit S[4:1] (index 0 flips P0), ErrorC=1; any other nonzero S: ErrorD=1, no correction.
REQ-021 Decoded word = {c[11:9], c[7:5], c[3]} of the (corrected) codeword c.
REQ-022 Accept occurs when i_Valid and o_Ready are both 1; decode is combinational on i_CodeWord, and the 9-bit result {ErrorD, ErrorC, data} is written to the FIFO tail on that edge.
REQ-023 Latency: a word accepted into an empty FIFO at edge N shows o_Valid=1 with its data from after edge N (one cycle); no combinational input-to-output path.
REQ-024 Pop occurs when o_Valid and i_Ready are both 1; head advances on that edge.
REQ-025 o_Ready = (o_Level < DEPTH); when full, o_Ready stays 0 even if a pop occurs that cycle.
REQ-026 Simultaneous accept and pop at non-empty, non-full level: o_Level unchanged, order preserved.
REQ-027 Pointers wrap modulo DEPTH; o_Valid = (o_Level != 0).
REQ-028 Output data and flags are held stable while o_Valid=1 and i_Ready=0.
REQ-029 DROP_UNCORR=1: an accepted word with ErrorD=1 is not written, o_Level is unchanged, and o_CntD still increments.
REQ-030 Counters increment by 1 on each accepted word with the matching flag and saturate at 255.
REQ-031 i_ClrCnt=1 forces both counters to 0 on that edge; it overrides any same-cycle increment.
REQ-032 i_ClrCnt has no effect on FIFO contents or handshake.

Reset
REQ-033 While i_Rst=1: o_Valid=0, o_Level=0, pointers=0, o_CntC=0, o_CntD=0, o_Ready=0.
REQ-034 While i_Rst=1: o_DecodWord=0, o_ErrorC=0, o_ErrorD=0.
REQ-035 After i_Rst deasserts, o_Ready=1 from the first following clock edge.
REQ-036 Reset asserted mid-stream discards all stored words immediately and returns the block to the state in REQ-033/034; no partial word survives.

Verification
REQ-037 Accept 0xFFF into empty FIFO, i_Ready=1 -> next cycle o_Valid=1, o_DecodWord=0x7F, ErrorC=0, ErrorD=0; counters unchanged.
REQ-038 Accept 0x020 (bit-5 error on zero word) -> o_DecodWord=0x00, ErrorC=1, o_CntC=1.
REQ-039 Accept 0x021 (double error) -> ErrorD=1, ErrorC=0, o_DecodWord=0x02, o_CntD=1; with DROP_UNCORR=1: no output word, o_Level=0, o_CntD=1.
REQ-040 Hold i_Ready=0 and push 5 words at DEPTH=4 -> o_Ready=0 after the 4th accept, 5th held upstream; then release i_Ready -> 4 words out in order, 5th accepted, no loss.
REQ-041 Drive 300 corrected words -> o_CntC saturates at 255; pulse i_ClrCnt during an accept -> counter reads 0 afterwards.
REQ-042 Assert i_Rst with 3 words queued -> o_Valid=0 and o_Level=0 immediately with no clock edge required; o_Ready=1 after the first edge following release.
